// File: rtl/connect4_pkg.sv
// connect4_pkg: board geometry, cell codes, arbiter states and row-start table
package connect4_pkg;
    localparam int ROWS   = 6;
    localparam int COLS   = 7;
    localparam int CELL_W = 2;
    localparam int ADDR_W = 6;
    localparam int ROW_AW = 3;
    localparam int ROW_W  = COLS * CELL_W;
    localparam int CELLS  = ROWS * COLS;

    typedef enum logic [CELL_W-1:0] {EMPTY = 2'd0, P1 = 2'd1, P2 = 2'd2} cell_t;

    typedef enum logic [2:0] {
        S_IDLE, S_V_RD, S_V_RET, S_G_RD, S_G_MOD, S_G_WR, S_CLR
    } arb_state_t;

    localparam logic [ROWS-1:0][ADDR_W-1:0] ROW_START =
        {6'd35, 6'd28, 6'd21, 6'd14, 6'd7, 6'd0};
endpackage

// File: rtl/cell_addr_decode.sv
// cell_addr_decode: cell index to {row, col, valid} by compare-subtract against row starts
module cell_addr_decode
    import connect4_pkg::*;
(
    input  logic [ADDR_W-1:0] addr,
    output logic [ROW_AW-1:0] row,
    output logic [ROW_AW-1:0] col,
    output logic              valid
);
    always_comb begin
        row = '0;
        col = addr[ROW_AW-1:0];
        for (int r = 1; r < ROWS; r++) begin
            if (addr >= ROW_START[r]) begin
                row = ROW_AW'(r);
                col = ROW_AW'(addr - ROW_START[r]);
            end
        end
        valid = addr < ADDR_W'(CELLS);
    end
endmodule

// File: rtl/board_mem_arbiter.sv
// board_mem_arbiter: single-port board RAM owner arbitrating VGA row reads,
// game-logic cell read/RMW-write and the new-game clear sweep.
module board_mem_arbiter
    import connect4_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              vga_rden,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [ROW_W-1:0]  vga_data,
    output logic              vga_ready,
    input  logic              gl_req,
    input  logic              gl_we,
    input  logic [ADDR_W-1:0] gl_addr,
    input  logic [CELL_W-1:0] gl_wdata,
    output logic [CELL_W-1:0] gl_rdata,
    output logic              gl_done,
    input  logic              clr_req,
    output logic              clr_done,
    output logic              busy,
    output logic [ROW_AW-1:0] ram_addr,
    output logic              ram_we,
    output logic [ROW_W-1:0]  ram_wdata,
    input  logic [ROW_W-1:0]  ram_rdata
);
    arb_state_t        state_q, state_d;
    logic [ROW_W-1:0]  vga_data_q, vga_data_d;
    logic              vga_ready_q, vga_ready_d;
    logic [CELL_W-1:0] gl_rdata_q, gl_rdata_d;
    logic              gl_done_q, gl_done_d;
    logic              clr_done_q, clr_done_d;
    logic [ROW_AW-1:0] ram_addr_q, ram_addr_d;
    logic              ram_we_q, ram_we_d;
    logic [ROW_W-1:0]  ram_wdata_q, ram_wdata_d;
    logic              v_arm_q, v_arm_d, g_arm_q, g_arm_d, c_arm_q, c_arm_d;
    logic              v_inv_q, v_inv_d, g_inv_q, g_inv_d, g_we_q, g_we_d;
    logic [CELL_W-1:0] g_wd_q, g_wd_d;
    logic [ROW_AW-1:0] g_col_q, g_col_d;
    logic [ROW_AW-1:0] v_row, v_col_unused, g_row, g_col;
    logic              v_valid, g_valid;
    logic [3:0]        sh;
    logic [ROW_W-1:0]  mask;

    cell_addr_decode u_vga_dec (.addr(vga_addr), .row(v_row), .col(v_col_unused), .valid(v_valid));
    cell_addr_decode u_gl_dec  (.addr(gl_addr),  .row(g_row), .col(g_col),        .valid(g_valid));

    always_comb begin
        state_d     = state_q;
        vga_data_d  = vga_data_q;
        vga_ready_d = 1'b0;
        gl_rdata_d  = gl_rdata_q;
        gl_done_d   = 1'b0;
        clr_done_d  = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_we_d    = 1'b0;
        ram_wdata_d = ram_wdata_q;
        // a requester re-arms once its request has been seen low
        v_arm_d     = v_arm_q | ~vga_rden;
        g_arm_d     = g_arm_q | ~gl_req;
        c_arm_d     = c_arm_q | ~clr_req;
        v_inv_d     = v_inv_q;
        g_inv_d     = g_inv_q;
        g_we_d      = g_we_q;
        g_wd_d      = g_wd_q;
        g_col_d     = g_col_q;
        sh          = {g_col_q, 1'b0};
        mask        = ROW_W'(2'b11) << sh;
        case (state_q)
            S_IDLE: begin
                if (vga_rden && v_arm_q) begin
                    state_d    = S_V_RD;
                    v_inv_d    = ~v_valid;
                    ram_addr_d = v_valid ? v_row : ram_addr_q;
                end else if (clr_req && c_arm_q) begin
                    state_d     = S_CLR;
                    ram_addr_d  = '0;
                    ram_we_d    = 1'b1;
                    ram_wdata_d = '0;
                end else if (gl_req && g_arm_q) begin
                    // out-of-range cells skip the RAM and finish from G_MOD
                    state_d    = g_valid ? S_G_RD : S_G_MOD;
                    g_inv_d    = ~g_valid;
                    g_we_d     = gl_we;
                    g_wd_d     = gl_wdata;
                    g_col_d    = g_col;
                    ram_addr_d = g_valid ? g_row : ram_addr_q;
                end
            end
            S_V_RD: state_d = S_V_RET;
            S_V_RET: begin
                vga_data_d  = v_inv_q ? '0 : ram_rdata;
                vga_ready_d = 1'b1;
                v_arm_d     = 1'b0;
                state_d     = S_IDLE;
            end
            S_G_RD: state_d = S_G_MOD;
            S_G_MOD: begin
                gl_rdata_d = g_inv_q ? '0 : CELL_W'(ram_rdata >> sh);
                if (g_we_q && !g_inv_q) begin
                    state_d     = S_G_WR;
                    ram_we_d    = 1'b1;
                    ram_wdata_d = (ram_rdata & ~mask) | (ROW_W'(g_wd_q) << sh);
                end else begin
                    gl_done_d = 1'b1;
                    g_arm_d   = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            S_G_WR: begin
                gl_done_d = 1'b1;
                g_arm_d   = 1'b0;
                state_d   = S_IDLE;
            end
            S_CLR: begin
                if (ram_addr_q == ROW_AW'(ROWS - 1)) begin
                    clr_done_d = 1'b1;
                    c_arm_d    = 1'b0;
                    state_d    = S_IDLE;
                end else begin
                    ram_addr_d = ram_addr_q + ROW_AW'(1);
                    ram_we_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            vga_data_q  <= '0;
            vga_ready_q <= 1'b0;
            gl_rdata_q  <= '0;
            gl_done_q   <= 1'b0;
            clr_done_q  <= 1'b0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
            v_arm_q     <= 1'b1;
            g_arm_q     <= 1'b1;
            c_arm_q     <= 1'b1;
            v_inv_q     <= 1'b0;
            g_inv_q     <= 1'b0;
            g_we_q      <= 1'b0;
            g_wd_q      <= '0;
            g_col_q     <= '0;
        end else begin
            state_q     <= state_d;
            vga_data_q  <= vga_data_d;
            vga_ready_q <= vga_ready_d;
            gl_rdata_q  <= gl_rdata_d;
            gl_done_q   <= gl_done_d;
            clr_done_q  <= clr_done_d;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
            v_arm_q     <= v_arm_d;
            g_arm_q     <= g_arm_d;
            c_arm_q     <= c_arm_d;
            v_inv_q     <= v_inv_d;
            g_inv_q     <= g_inv_d;
            g_we_q      <= g_we_d;
            g_wd_q      <= g_wd_d;
            g_col_q     <= g_col_d;
        end
    end

    assign vga_data  = vga_data_q;
    assign vga_ready = vga_ready_q;
    assign gl_rdata  = gl_rdata_q;
    assign gl_done   = gl_done_q;
    assign clr_done  = clr_done_q;
    assign ram_addr  = ram_addr_q;
    assign ram_we    = ram_we_q;
    assign ram_wdata = ram_wdata_q;
    assign busy      = state_q != S_IDLE;
endmodule

// File: tb/tb_board_mem_arbiter.sv
// tb_board_mem_arbiter: randomized bench checking the arbiter against a cell-array board model
module tb_board_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        vga_rden = 1'b0;
    logic [5:0]  vga_addr = '0;
    logic [13:0] vga_data;
    logic        vga_ready;
    logic        gl_req = 1'b0;
    logic        gl_we = 1'b0;
    logic [5:0]  gl_addr = '0;
    logic [1:0]  gl_wdata = '0;
    logic [1:0]  gl_rdata;
    logic        gl_done;
    logic        clr_req = 1'b0;
    logic        clr_done;
    logic        busy;
    logic [2:0]  ram_addr;
    logic        ram_we;
    logic [13:0] ram_wdata;
    logic [13:0] ram_rdata;

    always #5 clk = ~clk;

    board_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .vga_rden(vga_rden), .vga_addr(vga_addr), .vga_data(vga_data), .vga_ready(vga_ready),
        .gl_req(gl_req), .gl_we(gl_we), .gl_addr(gl_addr), .gl_wdata(gl_wdata),
        .gl_rdata(gl_rdata), .gl_done(gl_done),
        .clr_req(clr_req), .clr_done(clr_done), .busy(busy),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // RAM macro model with a backdoor port used only while the arbiter is idle
    logic [13:0] mem [6];
    logic        bd_we = 1'b0;
    logic [2:0]  bd_addr = '0;
    logic [13:0] bd_data = '0;
    always @(posedge clk) begin
        if (ram_we && ram_addr < 3'd6) mem[ram_addr] <= ram_wdata;
        else if (bd_we) mem[bd_addr] <= bd_data;
        ram_rdata <= (ram_addr < 3'd6) ? mem[ram_addr] : 14'h0;
    end

    int vectors = 0;
    int errs = 0;
    logic [1:0] board [42];

    function automatic logic [13:0] row_of(input int r);
        logic [13:0] v = '0;
        for (int c = 0; c < 7; c++) v[2*c +: 2] = board[r*7 + c];
        return v;
    endfunction

    task automatic bd_write(input int r, input logic [13:0] v);
        bd_addr = 3'(r); bd_data = v; bd_we = 1'b1;
        @(posedge clk); #1;
        bd_we = 1'b0;
        for (int c = 0; c < 7; c++) board[r*7 + c] = v[2*c +: 2];
    endtask

    task automatic vga_txn(input int a, output logic [13:0] d, output int lat, output logic extra);
        vga_addr = 6'(a); vga_rden = 1'b1; lat = -1; d = '0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (vga_ready) begin lat = i - 1; d = vga_data; break; end
        end
        @(posedge clk); #1;
        extra = vga_ready;
        vga_rden = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic gl_txn(input int a, input logic we, input logic [1:0] wd,
                          output logic [1:0] rd, output int lat, output int wes, output logic extra);
        gl_addr = 6'(a); gl_we = we; gl_wdata = wd; gl_req = 1'b1; lat = -1; wes = 0; rd = '0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            wes += int'(ram_we);
            if (gl_done) begin lat = i - 1; rd = gl_rdata; break; end
        end
        @(posedge clk); #1;
        extra = gl_done;
        wes += int'(ram_we);
        gl_req = 1'b0;
        @(posedge clk); #1;
        wes += int'(ram_we);
    endtask

    task automatic clr_txn(output int lat, output int wcnt, output logic seq_ok, output logic extra);
        clr_req = 1'b1; lat = -1; wcnt = 0; seq_ok = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (ram_we) begin
                if (int'(ram_addr) != wcnt || ram_wdata != 14'h0 || i != wcnt + 1) seq_ok = 1'b0;
                wcnt++;
            end
            if (clr_done) begin lat = i - 1; break; end
        end
        @(posedge clk); #1;
        extra = clr_done | ram_we;
        clr_req = 1'b0;
        for (int c = 0; c < 42; c++) board[c] = 2'd0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({vga_data, vga_ready, gl_rdata, gl_done, clr_done, busy, ram_we, ram_addr, ram_wdata} !== '0) begin
            errs++;
            $display("FAIL reset_outputs: got vga_data=%h rdy=%b gl_rdata=%h done=%b clr=%b busy=%b we=%b addr=%h wdata=%h, need all 0",
                     vga_data, vga_ready, gl_rdata, gl_done, clr_done, busy, ram_we, ram_addr, ram_wdata);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        for (int r = 0; r < 6; r++) bd_write(r, 14'($urandom));
    endtask

    task automatic test_vga_read();
        logic [13:0] d; int lat; logic extra;
        bd_write(2, 14'h2A55);
        vga_txn(14, d, lat, extra);
        vectors++;
        if (d !== 14'h2A55) begin errs++; $display("FAIL vga_row2_data: got %h need 2a55", d); end
        vectors++;
        if (lat != 2) begin errs++; $display("FAIL vga_row2_latency: got %0d need 2", lat); end
        vectors++;
        if (extra !== 1'b0) begin errs++; $display("FAIL vga_single_pulse: got extra ready %b need 0", extra); end
    endtask

    task automatic test_gl_write();
        logic [1:0] rd; int lat, wes; logic extra;
        bd_write(1, 14'h0);
        gl_txn(10, 1'b1, 2'd2, rd, lat, wes, extra);
        board[10] = 2'd2;
        vectors++;
        if (rd !== 2'd0) begin errs++; $display("FAIL glw_old_value: got %0d need 0", rd); end
        vectors++;
        if (lat != 3) begin errs++; $display("FAIL glw_latency: got %0d need 3", lat); end
        vectors++;
        if (wes != 1 || extra !== 1'b0) begin errs++; $display("FAIL glw_we_count: got we=%0d extra=%b need 1/0", wes, extra); end
        vectors++;
        if (mem[1] !== 14'h0080) begin errs++; $display("FAIL glw_row1: got %h need 0080", mem[1]); end
        for (int r = 0; r < 6; r++) begin
            vectors++;
            if (mem[r] !== row_of(r)) begin errs++; $display("FAIL glw_row%0d_intact: got %h need %h", r, mem[r], row_of(r)); end
        end
    endtask

    task automatic test_gl_read();
        logic [1:0] rd; int lat, wes; logic extra;
        gl_txn(10, 1'b0, 2'd0, rd, lat, wes, extra);
        vectors++;
        if (rd !== 2'd2) begin errs++; $display("FAIL glr_value: got %0d need 2", rd); end
        vectors++;
        if (lat != 2) begin errs++; $display("FAIL glr_latency: got %0d need 2", lat); end
        vectors++;
        if (wes != 0) begin errs++; $display("FAIL glr_no_write: got %0d write cycles need 0", wes); end
    endtask

    task automatic test_clear();
        int lat, wcnt; logic ok, extra; logic [13:0] d; int vl; logic vx;
        for (int r = 0; r < 6; r++) bd_write(r, 14'h3FFF);
        clr_txn(lat, wcnt, ok, extra);
        vectors++;
        if (wcnt != 6 || !ok) begin errs++; $display("FAIL clr_sweep: got %0d writes in_order=%b need 6/1", wcnt, ok); end
        vectors++;
        if (lat != 6 || extra !== 1'b0) begin errs++; $display("FAIL clr_done_timing: got lat=%0d extra=%b need 6/0", lat, extra); end
        for (int r = 0; r < 6; r++) begin
            vga_txn(r * 7, d, vl, vx);
            vectors++;
            if (d !== 14'h0 || vl != 2) begin errs++; $display("FAIL clr_readback_row%0d: got %h lat %0d need 0000 lat 2", r, d, vl); end
        end
    endtask

    task automatic test_simultaneous();
        logic [13:0] d; int vl, gl, wes; logic vx, gx; logic [1:0] rd; logic [1:0] nv;
        nv = board[25] ^ 2'd1;
        fork
            vga_txn(21, d, vl, vx);
            gl_txn(25, 1'b1, nv, rd, gl, wes, gx);
        join
        vectors++;
        if (vl != 2 || d !== row_of(3)) begin errs++; $display("FAIL simul_vga_first: got lat %0d data %h need 2 %h", vl, d, row_of(3)); end
        vectors++;
        if (gl != 6 || rd !== board[25]) begin errs++; $display("FAIL simul_gl_after: got lat %0d rd %0d need 6 %0d", gl, rd, board[25]); end
        board[25] = nv;
        nv = board[40] ^ 2'd2;
        fork
            gl_txn(40, 1'b1, nv, rd, gl, wes, gx);
            begin @(posedge clk); #1; vga_txn(35, d, vl, vx); end
        join
        board[40] = nv;
        vectors++;
        if (gl != 3) begin errs++; $display("FAIL rmw_not_preempted: got gl lat %0d need 3", gl); end
        vectors++;
        if (vl != 5 || d !== row_of(5)) begin errs++; $display("FAIL vga_delayed_by_rmw: got lat %0d data %h need 5 %h", vl, d, row_of(5)); end
    endtask

    task automatic test_reset_mid_rmw();
        int we_seen = 0; logic [1:0] rd; int lat, wes; logic extra; logic [13:0] d; int vl; logic vx;
        gl_addr = 6'd20; gl_we = 1'b1; gl_wdata = ~board[20]; gl_req = 1'b1;
        repeat (2) begin @(posedge clk); #1; we_seen += int'(ram_we); end
        rst = 1'b0; gl_req = 1'b0;
        @(posedge clk); #1;
        we_seen += int'(ram_we);
        vectors++;
        if ({vga_data, vga_ready, gl_rdata, gl_done, clr_done, busy, ram_we, ram_addr, ram_wdata} !== '0) begin
            errs++;
            $display("FAIL midrmw_reset_outputs: got gl_rdata=%h done=%b busy=%b we=%b addr=%h wdata=%h need all 0",
                     gl_rdata, gl_done, busy, ram_we, ram_addr, ram_wdata);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; we_seen += int'(ram_we); end
        vectors++;
        if (we_seen != 0) begin errs++; $display("FAIL midrmw_no_write: got %0d write cycles need 0", we_seen); end
        for (int r = 0; r < 6; r++) begin
            vectors++;
            if (mem[r] !== row_of(r)) begin errs++; $display("FAIL midrmw_row%0d: got %h need %h", r, mem[r], row_of(r)); end
        end
        gl_txn(45, 1'b1, 2'd3, rd, lat, wes, extra);
        vectors++;
        if (rd !== 2'd0 || lat != 1 || wes != 0) begin errs++; $display("FAIL gl_addr45: got rd %0d lat %0d we %0d need 0 1 0", rd, lat, wes); end
        vga_txn(50, d, vl, vx);
        vectors++;
        if (d !== 14'h0 || vl != 2) begin errs++; $display("FAIL vga_addr50: got %h lat %0d need 0000 2", d, vl); end
    endtask

    task automatic test_random();
        logic [13:0] d; int lat, wes, wcnt, a, r; logic extra, ok; logic [1:0] rd, wd, exp_rd; logic we;
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: begin
                    r = int'($urandom_range(0, 6));
                    a = (r < 6) ? r * 7 : int'($urandom_range(42, 63));
                    vga_txn(a, d, lat, extra);
                    vectors++;
                    if (d !== ((a < 42) ? row_of(a / 7) : 14'h0) || lat != 2 || extra !== 1'b0) begin
                        errs++;
                        $display("FAIL rnd_vga addr %0d: got %h lat %0d extra %b need %h lat 2",
                                 a, d, lat, extra, (a < 42) ? row_of(a / 7) : 14'h0);
                    end
                end
                9: begin
                    clr_txn(lat, wcnt, ok, extra);
                    vectors++;
                    if (lat != 6 || wcnt != 6 || !ok) begin errs++; $display("FAIL rnd_clear: got lat %0d writes %0d ok %b need 6 6 1", lat, wcnt, ok); end
                end
                default: begin
                    a = int'($urandom_range(0, 47));
                    we = 1'($urandom);
                    wd = 2'($urandom);
                    exp_rd = (a < 42) ? board[a] : 2'd0;
                    gl_txn(a, we, wd, rd, lat, wes, extra);
                    vectors++;
                    if (rd !== exp_rd || lat != ((a >= 42) ? 1 : (we ? 3 : 2)) ||
                        wes != ((a < 42 && we) ? 1 : 0) || extra !== 1'b0) begin
                        errs++;
                        $display("FAIL rnd_gl addr %0d we %b: got rd %0d lat %0d writes %0d need rd %0d", a, we, rd, lat, wes, exp_rd);
                    end
                    if (a < 42 && we) board[a] = wd;
                end
            endcase
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        for (int k = 0; k < 6; k++) begin
            vectors++;
            if (mem[k] !== row_of(k)) begin errs++; $display("FAIL rnd_final_row%0d: got %h need %h", k, mem[k], row_of(k)); end
        end
    endtask

    initial begin
        test_reset();
        test_vga_read();
        test_gl_write();
        test_gl_read();
        test_clear();
        test_simultaneous();
        test_reset_mid_rmw();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d vectors applied, %0d miscompares", vectors, errs);
        $fatal(1);
    end
endmodule

// File: doc/board_mem_arbiter.md
Name: board_mem_arbiter

Overview:
- Sole owner of the single-port board RAM, which holds 6 rows × 14 bits (7 cells × 2 bits).
- Arbitrates between three requesters:
  - VGA row reader: cell-index address, full-row return.
  - Game-logic cell read/write: a write is performed as an atomic read-modify-write of one row.
  - Board-clear sweep for a new game.
- Sits between the VGA renderer / game FSM and the RAM macro.

Parameters:
- ROWS, 6, number of board rows
- COLS, 7, cells per row
- CELL_W, 2, bits per cell (0 = empty, 1 = player1, 2 = player2)
- ADDR_W, 6, cell-index address width
- ROW_AW, 3, RAM row address width

Ports:
- clk  in  1  system clock (25 MHz pixel clock)
- rst  in  1  synchronous, active-low reset
- vga_rden  in  1  VGA row read request; held high until vga_ready
- vga_addr  in  6  cell index of first cell of row (row*7)
- vga_data  out  14  row contents; cell c in bits [2c+1:2c]
- vga_ready  out  1  one-cycle pulse; vga_data valid in the same cycle
- gl_req  in  1  game-logic request; held high until gl_done
- gl_we  in  1  1 = write cell, 0 = read cell
- gl_addr  in  6  cell index 0..41 (row*7+col)
- gl_wdata  in  2  cell value to write
- gl_rdata  out  2  cell value before the operation
- gl_done  out  1  one-cycle completion pulse
- clr_req  in  1  start board clear; held high until clr_done
- clr_done  out  1  one-cycle completion pulse
- busy  out  1  high in any non-IDLE state
- ram_addr  out  3  RAM row address
- ram_we  out  1  RAM write enable
- ram_wdata  out  14  RAM write data
- ram_rdata  in  14  RAM read data, valid one cycle after address with ram_we=0

Behaviour:
- **Reset** (rst=0 at an edge):
  - state=IDLE.
  - vga_data=0, vga_ready=0, gl_rdata=0, gl_done=0, clr_done=0, ram_we=0, ram_addr=0, ram_wdata=0.
  - Re-arm flags set.
  - RAM contents untouched.
  - An interrupted RMW does not write if ram_we was not yet asserted.
- **Outputs**: all handshake and data outputs are registered.
- **Address decode**: row = addr/7, col = addr%7, computed by compare-subtract with no divider.
  - VGA addr ≥ 42: serviced without RAM access; vga_data=0 with a normal ready pulse.
  - GL addr ≥ 42: no RAM access; gl_rdata=0, gl_done after 1 cycle.
- **Priority in IDLE**: VGA > clear > GL, evaluated every IDLE cycle.
  - Operations are non-preemptive; a started RMW or clear sweep always completes.
- **Re-arm**: after a done/ready pulse, a requester is not serviced again until its request has been sampled low at least once. This prevents double service when the requester drops its request one cycle late.
- **States**:
  - IDLE: choose a request.
  - V_RD: ram_addr=row.
  - V_RET: capture ram_rdata into vga_data; pulse vga_ready; go to IDLE.
  - G_RD: ram_addr=row.
  - G_MOD: capture the old cell into gl_rdata.
    - If read: pulse gl_done, go to IDLE.
    - If write: build the new row with only cell col replaced; go to G_WR.
  - G_WR: ram_we=1 with the new row; pulse gl_done; go to IDLE.
  - CLR: write row 0..ROWS-1 with 0, one row per cycle; after the row 5 write, pulse clr_done and go to IDLE.
- **Latency**, counted from the IDLE edge that accepts the request:
  - VGA read: ready 2 cycles later.
  - GL read: done 2 cycles later.
  - GL write: 3 cycles.
  - Clear: 6 write cycles plus the done pulse.
- **Simultaneous requests**: the lower-priority requester waits while its request stays held. VGA worst-case wait is 6 cycles (during a clear), well within the 10-cycle request window.
- **Write data**: writes with gl_wdata=3 are performed as given; no legality checks are made on cell values.

Decomposition:
- Shared package connect4_pkg:
  - ROWS, COLS, CELL_W constants.
  - Cell codes EMPTY/P1/P2.
  - Arbiter state encoding.
  - Row-start address table (0,7,14,21,28,35).
- One sub-module, cell_addr_decode: combinational 6-bit index → {row[2:0], col[2:0], valid}.
  - Instantiated twice, once for VGA and once for GL.

Test Plan:
- Reset, then VGA rden with addr=14, RAM row2=0x2A55 → vga_ready exactly 2 cycles after acceptance, vga_data=0x2A55, one pulse only while rden is held one extra cycle.
- GL write addr=10 (row1, col3), wdata=2, row1 initially 0 → gl_rdata=0, gl_done at cycle 3, RAM row1=0x0080, no other row or bits changed.
- GL read addr=10 after the above → gl_rdata=2, gl_done at cycle 2, ram_we never asserted.
- clr_req with all rows =0x3FFF → 6 consecutive ram_we cycles at addr 0..5 with data 0, then a clr_done pulse; readback of every row =0.
- VGA and GL requests in the same cycle → VGA ready first; GL RMW starts immediately after; GL RMW in progress delays a new VGA request by ≤3 cycles.
- rst low during G_MOD of a write, and GL addr=45 after reset → no RAM write occurs, all outputs 0; addr=45 gives gl_done after 1 cycle with gl_rdata=0.
